// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register carrying PC, instruction, payload, exception code and BD flag,
// with exception-entry redirect, stall hold, bubble flush and a saturating stall counter.
module pipe_stage_reg #(
    parameter int          DW         = 128,
    parameter int          EXC_W      = 5,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_ir,
    input  logic [DW-1:0]    in_data,
    input  logic [EXC_W-1:0] in_exc,
    input  logic             in_bd,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_ir,
    output logic [DW-1:0]    out_data,
    output logic [EXC_W-1:0] out_exc,
    output logic             out_bd,
    output logic [15:0]      stall_cnt
);

    logic             valid_q, valid_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [DW-1:0]    data_q, data_d;
    logic [EXC_W-1:0] exc_q, exc_d;
    logic             bd_q, bd_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        data_d      = data_q;
        exc_d       = exc_q;
        bd_d        = bd_q;
        stall_cnt_d = 16'd0;
        if (req) begin
            valid_d = 1'b0;
            pc_d    = HANDLER_PC;
            ir_d    = '0;
            data_d  = '0;
            exc_d   = '0;
            bd_d    = 1'b0;
        end else if (stall) begin
            stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
        end else if (flush) begin
            // PC and BD survive the bubble so an interrupt taken on it reports the right EPC
            valid_d = 1'b0;
            pc_d    = in_pc;
            ir_d    = '0;
            data_d  = '0;
            exc_d   = '0;
            bd_d    = in_bd;
        end else begin
            valid_d = in_valid;
            pc_d    = in_pc;
            ir_d    = in_ir;
            data_d  = in_data;
            exc_d   = in_valid ? in_exc : '0;
            bd_d    = in_bd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            data_q      <= '0;
            exc_q       <= '0;
            bd_q        <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            data_q      <= data_d;
            exc_q       <= exc_d;
            bd_q        <= bd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign out_ir    = ir_q;
    assign out_data  = data_q;
    assign out_exc   = exc_q;
    assign out_bd    = bd_q;
    assign stall_cnt = stall_cnt_q;

endmodule
